// File: rtl/rr_arb_mux_pkg.sv
// Shared round-robin helpers: grant-index width and a rotating priority search.
// Used by rr_arbiter; optional packet locking in rr_arb_mux is RR_ARB_MUX_LAST_EN.
package rr_arb_mux_pkg;

  localparam int unsigned MaxCh   = 16;
  localparam int unsigned MaxIdxW = 4;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned idx_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // First set bit of valid at or after ptr, wrapping modulo nch.
  function automatic rr_pick_t rr_pick(input logic [MaxCh-1:0]   valid,
                                       input logic [MaxIdxW-1:0] ptr,
                                       input int unsigned        nch);
    rr_pick_t    res;
    int unsigned ch;
    res = '0;
    for (int unsigned k = 0; k < MaxCh; k++) begin
      ch = (32'(ptr) + k) % nch;
      if (k < nch && !res.found && valid[ch[MaxIdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = ch[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward with wrap-around.
// Independent of RR_ARB_MUX_LAST_EN; locking is applied by masking req upstream.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned IDXW = idx_width(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_onehot_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            gnt_any_o
);

  logic [MaxCh-1:0] req_ext;
  rr_pick_t         pick;
  logic             unused_pick;

  always_comb begin
    req_ext             = '0;
    req_ext[NCH-1:0]    = req_i;
    pick                = rr_pick(req_ext, MaxIdxW'(ptr_i), NCH);
    gnt_any_o           = pick.found;
    gnt_idx_o           = pick.idx[IDXW-1:0];
    gnt_onehot_o        = '0;
    if (pick.found) begin
      gnt_onehot_o[gnt_idx_o] = 1'b1;
    end
    unused_pick = ^pick.idx;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// NCH-way round-robin arbitrating mux with one registered output beat and valid/ready.
// Define RR_ARB_MUX_LAST_EN to add in_last/out_last and hold the grant for a whole packet.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned IDXW  = idx_width(NCH)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NCH-1:0]       in_valid_i,
  input  logic [NCH*WIDTH-1:0] in_data_i,
  output logic [NCH-1:0]       in_ready_o,
`ifdef RR_ARB_MUX_LAST_EN
  input  logic [NCH-1:0]       in_last_i,
  output logic                 out_last_o,
`endif
  output logic                 out_valid_o,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [IDXW-1:0]      out_idx_o,
  input  logic                 out_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   gnt_onehot;
  logic [IDXW-1:0]  gnt_idx;
  logic [IDXW-1:0]  ptr_inc;
  logic             gnt_any;

  assign load = ~out_valid_q | out_ready_i;

`ifdef RR_ARB_MUX_LAST_EN
  logic lock_q, lock_d;
  logic out_last_q, out_last_d;

  // out_idx_q always names the last channel that transferred, i.e. the lock owner.
  always_comb begin
    req = in_valid_i;
    if (lock_q) begin
      req            = '0;
      req[out_idx_q] = in_valid_i[out_idx_q];
    end
  end
`else
  assign req = in_valid_i;
`endif

  rr_arbiter #(
    .NCH (NCH),
    .IDXW(IDXW)
  ) u_arbiter (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_onehot_o(gnt_onehot),
    .gnt_idx_o   (gnt_idx),
    .gnt_any_o   (gnt_any)
  );

  assign in_ready_o = gnt_onehot & {NCH{load & rstn_i}};
  assign ptr_inc    = (gnt_idx == IDXW'(NCH - 1)) ? '0 : gnt_idx + IDXW'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LAST_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = in_data_i[gnt_idx*WIDTH +: WIDTH];
        out_idx_d  = gnt_idx;
`ifdef RR_ARB_MUX_LAST_EN
        out_last_d = in_last_i[gnt_idx];
        lock_d     = ~in_last_i[gnt_idx];
        if (in_last_i[gnt_idx]) begin
          ptr_d = ptr_inc;
        end
`else
        ptr_d      = ptr_inc;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_ARB_MUX_LAST_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LAST_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
`ifdef RR_ARB_MUX_LAST_EN
  assign out_last_o  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (NCH=4 main instance, NCH=3 instance for wrap checks).
// Packet-lock checks are compiled in when RR_ARB_MUX_LAST_EN is defined.
module tb_rr_arb_mux;
  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_idx;

  logic [2:0]  v3, r3;
  logic [23:0] d3;
  logic        ov3, or3;
  logic [7:0]  od3;
  logic [1:0]  oi3;

`ifdef RR_ARB_MUX_LAST_EN
  logic [N-1:0] in_last;
  logic         out_last;
  logic [2:0]   l3;
  logic         ol3;
`endif

  rr_arb_mux #(.WIDTH(W), .NCH(N)) u_dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
`ifdef RR_ARB_MUX_LAST_EN
    .in_last_i  (in_last),
    .out_last_o (out_last),
`endif
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_idx_o  (out_idx),
    .out_ready_i(out_ready)
  );

  rr_arb_mux #(.WIDTH(8), .NCH(3)) u_dut3 (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .in_valid_i (v3),
    .in_data_i  (d3),
    .in_ready_o (r3),
`ifdef RR_ARB_MUX_LAST_EN
    .in_last_i  (l3),
    .out_last_o (ol3),
`endif
    .out_valid_o(ov3),
    .out_data_o (od3),
    .out_idx_o  (oi3),
    .out_ready_i(or3)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mode     = 0;
  int          gap      = 0;
  int unsigned exp_seq[N];
  int unsigned off_seq[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] d);
    exp_q.push_back({idx[1:0], d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat is checked against the scoreboard.
  always @(negedge clk) begin : mon
    beat_t e;
    if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (mode == 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(out_idx), 64'hffff);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", 64'(out_idx), 64'(e.idx));
          chk("beat_data", 64'(out_data), 64'(e.data));
        end
      end else begin
        chk("rand_data", 64'(out_data), 64'({6'd0, out_idx, exp_seq[out_idx][23:0]}));
        exp_seq[out_idx]++;
        if (out_idx == 2'd0) begin
          chk("ch0_wait", 64'(gap <= 3), 64'd1);
          gap = 0;
        end else begin
          gap++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    rstn      = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'hA0 + k;
    v3  = '0;
    or3 = 1'b1;
    d3  = {8'h12, 8'h11, 8'h10};
`ifdef RR_ARB_MUX_LAST_EN
    in_last = '1;
    l3      = '1;
`endif
    for (int k = 0; k < N; k++) begin
      exp_seq[k] = 0;
      off_seq[k] = 0;
    end

    // Reset with all channels requesting
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);

    // Release: round-robin 0,1,2,3,0
    step();
    rstn = 1'b1;
    push(0, 32'hA0); push(1, 32'hA1); push(2, 32'hA2); push(3, 32'hA3); push(0, 32'hA0);
    @(negedge clk);
    chk("first_grant", 64'(in_ready), 64'b0001);
    step();
    @(negedge clk);
    chk("first_out_valid", 64'(out_valid), 64'd1);
    step(); step(); step(); step();
    in_valid = '0;
    step();
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_hold_idx", 64'(out_idx), 64'd0);
    chk("idle_hold_data", 64'(out_data), 64'hA0);

    // Backpressure: ptr=1
    step();
    in_valid  = '1;
    out_ready = 1'b0;
    push(1, 32'hA1); push(2, 32'hA2);
    @(negedge clk);
    chk("bp_first_grant", 64'(in_ready), 64'b0010);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_idx", 64'(out_idx), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'hA1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill_grant", 64'(in_ready), 64'b0100);
    step();
    in_valid = '0;
    step();

    // Sparse requests: ptr=3
    in_valid = 4'b0010;
    push(1, 32'hA1);
    @(negedge clk);
    chk("sparse_ptr3", 64'(in_ready), 64'b0010);
    step();
    in_valid = 4'b1011;
    push(3, 32'hA3);
    @(negedge clk);
    chk("sparse_ptr2", 64'(in_ready), 64'b1000);
    step();
    in_valid = '0;
    step(); step(); step();
    in_valid = 4'b1001;
    push(0, 32'hA0);
    @(negedge clk);
    chk("ptr_idle_stable", 64'(in_ready), 64'b0001);
    step();
    in_valid = '0;
    step();

    // Reset discards a held beat; ptr returns to 0
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    step();
    in_valid = '0;
    @(negedge clk);
    chk("held_before_rst", 64'(out_valid), 64'd1);
    step();
    rstn     = 1'b0;
    in_valid = '1;
    @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_idx", 64'(out_idx), 64'd0);
    step();
    rstn      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1010;
    push(1, 32'hA1);
    @(negedge clk);
    chk("post_rst_ptr0", 64'(in_ready), 64'b0010);
    step();
    in_valid = '0;
    step(); step();

    // NCH=3 wrap
    v3 = 3'b100;
    @(negedge clk);
    chk("n3_grant2", 64'(r3), 64'b100);
    step();
    v3 = 3'b011;
    @(negedge clk);
    chk("n3_wrap_ptr0", 64'(r3), 64'b001);
    chk("n3_out_idx", 64'(oi3), 64'd2);
    chk("n3_out_data", 64'(od3), 64'h12);
    step();
    v3 = 3'b111;
    @(negedge clk);
    chk("n3_ptr1", 64'(r3), 64'b010);
    chk("n3_out_idx0", 64'(oi3), 64'd0);
    chk("n3_out_data0", 64'(od3), 64'h10);
    step();
    v3 = '0;
    step();
    chk("directed_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic: ch0 always requesting, per-channel sequence check
    mode     = 1;
    in_valid = '0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      step();
      for (int ch = 0; ch < N; ch++) if (acc[ch]) in_valid[ch] = 1'b0;
      if (cyc < 1000) begin
        for (int ch = 0; ch < N; ch++) begin
          if (!in_valid[ch] && (ch == 0 || $urandom_range(1) == 1)) begin
            in_data[ch*W +: W] = {8'(ch), off_seq[ch][23:0]};
            off_seq[ch]++;
            in_valid[ch] = 1'b1;
          end
        end
        out_ready = ($urandom_range(3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
    chk("rand_all_accepted", 64'(in_valid), 64'd0);
    for (int ch = 0; ch < N; ch++) chk("rand_beat_count", 64'(exp_seq[ch]), 64'(off_seq[ch]));
    chk("rand_final_gap", 64'(gap <= 3), 64'd1);
    mode = 0;

`ifdef RR_ARB_MUX_LAST_EN
    // Packet lock: ch1 three beats, pause mid-packet, ch2 waits
    rstn = 1'b0;
    step();
    rstn     = 1'b1;
    in_last  = 4'b1101;
    in_data[1*W +: W] = 32'hB0;
    in_data[2*W +: W] = 32'hC0;
    in_valid = 4'b0110;
    push(1, 32'hB0); push(1, 32'hB1); push(1, 32'hB2); push(2, 32'hC0);
    step();
    in_data[1*W +: W] = 32'hB1;
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("lock_blocks_ch2", 64'(in_ready), 64'd0);
    step();
    in_valid[1] = 1'b1;
    in_data[1*W +: W] = 32'hB2;
    in_last[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("out_last_set", 64'(out_last), 64'd1);
    step();
    in_valid = '0;
    step(); step();
    chk("last_drained", 64'(exp_q.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
